systolic_output_deskew: RTL and testbench

Output-side collector for the systolic MAC array. The array emits results column-skewed: column j's data is valid j cycles after column 0, mirroring the staggered row-enable ramp used on the input side. This block removes the skew with per-column delay lines and reassembles aligned rows. It buffers the rows in a small FIFO and presents them downstream on a valid/ready handshake, with sticky error flags and a row counter.

---
 rtl/systolic_output_deskew.sv | 176 +++++++++++++++++
 tb/tb_systolic_output_deskew.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
// Removes the column skew from the systolic array's result stream. Each lane
// is delayed so that every lane lines up with the last lane. Complete rows
// are buffered in a small FIFO and handed downstream on a valid/ready
// handshake. Sticky flags report dropped rows and inconsistent lane valids.

module systolic_output_deskew #(
  parameter int ARRAY_SIZE = 9,
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            s_clk,
  input  logic                            s_reset,
  input  logic                            clear,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0] col_data,
  input  logic [ARRAY_SIZE-1:0]           col_valid,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [15:0]                     row_count,
  output logic                            overflow,
  output logic                            skew_error,
  output logic                            busy
);

  localparam int ROW_W = ARRAY_SIZE * DATA_SIZE;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [ARRAY_SIZE-1:0] aligned_valid;
  logic [ARRAY_SIZE-1:0] lane_busy;
  logic [ROW_W-1:0]      aligned_data;

  // Per-lane delay lines: lane j needs ARRAY_SIZE-1-j stages so that all lanes
  // line up with the last lane, which passes straight through.
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    localparam int D = ARRAY_SIZE - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned_valid[j]                        = col_valid[j];
      assign aligned_data[j*DATA_SIZE +: DATA_SIZE]  = col_data[j*DATA_SIZE +: DATA_SIZE];
      assign lane_busy[j]                            = 1'b0;
    end else begin : g_dly
      logic [D-1:0]         v_sr;
      logic [DATA_SIZE-1:0] d_sr [D];

      // Shift valid and data one stage per cycle; clear only drops the valids.
      always_ff @(posedge s_clk or negedge s_reset) begin
        if (!s_reset) begin
          v_sr <= '0;
          for (int k = 0; k < D; k++) begin
            d_sr[k] <= '0;
          end
        end else begin
          d_sr[0] <= col_data[j*DATA_SIZE +: DATA_SIZE];
          for (int k = 1; k < D; k++) begin
            d_sr[k] <= d_sr[k-1];
          end
          if (clear) begin
            v_sr <= '0;
          end else begin
            v_sr[0] <= col_valid[j];
            for (int k = 1; k < D; k++) begin
              v_sr[k] <= v_sr[k-1];
            end
          end
        end
      end

      assign aligned_valid[j]                       = v_sr[D-1];
      assign aligned_data[j*DATA_SIZE +: DATA_SIZE] = d_sr[D-1];
      assign lane_busy[j]                           = |v_sr;
    end
  end

  logic             push;
  logic             skew_hit;
  logic             pop;
  logic             full;
  logic             accept;
  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [ROW_W-1:0] head_next;

  // A row exists only when every lane agrees; partial agreement is a fault.
  assign push       = &aligned_valid;
  assign skew_hit   = (|aligned_valid) & ~push;
  assign full       = (count == CNT_FULL);
  assign pop        = out_valid & out_ready;
  assign accept     = push & (~full | pop);
  assign rd_ptr_inc = rd_ptr + PTR_ONE;
  assign busy       = (|lane_busy) | out_valid;

  // Next occupancy and next value of the registered head.
  always_comb begin
    count_next = count;
    head_next  = out_data;
    if (accept && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !accept) begin
      count_next = count - CNT_ONE;
    end else begin
      count_next = count;
    end
    if (pop) begin
      if (count > CNT_ONE) begin
        head_next = mem[rd_ptr_inc];
      end else if (accept) begin
        head_next = aligned_data;
      end else begin
        head_next = out_data;
      end
    end else if (accept && (count == '0)) begin
      head_next = aligned_data;
    end else begin
      head_next = out_data;
    end
  end

  // Row storage; the slot under the write pointer is filled on every accept.
  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear && accept) begin
      mem[wr_ptr] <= aligned_data;
    end
  end

  // FIFO pointers, registered head/valid, row counter and sticky flags.
  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      row_count  <= 16'd0;
      overflow   <= 1'b0;
      skew_error <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      row_count  <= 16'd0;
      overflow   <= 1'b0;
      skew_error <= 1'b0;
    end else begin
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_data  <= head_next;
      if (accept) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        row_count <= row_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      if (skew_hit) begin
        skew_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Bench for systolic_output_deskew: directed scenarios plus a random phase,
// all checked every cycle against a row-level reference model.

module tb_systolic_output_deskew;

  localparam int N     = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = N * DW;
  localparam int SCHED = 4096;

  logic          s_clk = 1'b0;
  logic          s_reset;
  logic          clear;
  logic [W-1:0]  col_data;
  logic [N-1:0]  col_valid;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   row_count;
  logic          overflow;
  logic          skew_error;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 s_clk = ~s_clk;

  systolic_output_deskew #(
    .ARRAY_SIZE(N), .DATA_SIZE(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .s_clk(s_clk), .s_reset(s_reset), .clear(clear),
    .col_data(col_data), .col_valid(col_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .row_count(row_count), .overflow(overflow), .skew_error(skew_error),
    .busy(busy)
  );

  // Launch schedule: a row started at cycle c drives lane j at cycle c+j.
  logic [W-1:0] row_at [SCHED];
  bit           row_on [SCHED];
  bit           flat_on;
  logic [W-1:0] flat_data;

  // Reference model: input history, row queue, counter and flags.
  logic [W-1:0] q[$];
  logic [15:0]  m_cnt;
  bit           m_ovf;
  bit           m_skew;
  logic [N-1:0] hv [N-1];
  logic [W-1:0] hd [N-1];
  logic [W-1:0] rows [6];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = 16'd0;
    m_ovf  = 1'b0;
    m_skew = 1'b0;
    for (int k = 0; k < N-1; k++) begin
      hv[k] = '0;
      hd[k] = '0;
    end
  endtask

  task automatic flush_sched();
    for (int i = 0; i < SCHED; i++) row_on[i] = 1'b0;
    flat_on = 1'b0;
  endtask

  // One rising edge of the model. hv[k]/hd[k] is the sample taken k+1 edges ago.
  task automatic model_edge(input logic [N-1:0] cv, input logic [W-1:0] cd,
                            input logic rdy, input logic clr);
    logic [N-1:0] av;
    logic [W-1:0] ad;
    if (!s_reset || clr) begin
      model_reset();
    end else begin
      for (int j = 0; j < N; j++) begin
        int d;
        d = N - 1 - j;
        if (d == 0) begin
          av[j] = cv[j];
          ad[j*DW +: DW] = cd[j*DW +: DW];
        end else begin
          av[j] = hv[d-1][j];
          ad[j*DW +: DW] = hd[d-1][j*DW +: DW];
        end
      end
      if ((q.size() > 0) && rdy) void'(q.pop_front());
      if (&av) begin
        if (q.size() < DEPTH) begin
          q.push_back(ad);
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (|av) begin
        m_skew = 1'b1;
      end
      for (int k = N-2; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      hv[0] = cv;
      hd[0] = cd;
    end
  endtask

  task automatic compare_all();
    bit eb;
    eb = (q.size() > 0);
    for (int j = 0; j < N-1; j++)
      for (int k = 0; k < N-1-j; k++)
        if (hv[k][j]) eb = 1'b1;
    check("out_valid", W'(out_valid), W'(q.size() > 0));
    if (q.size() > 0) check("out_data", out_data, q[0]);
    check("row_count", W'(row_count), W'(m_cnt));
    check("overflow", W'(overflow), W'(m_ovf));
    check("skew_error", W'(skew_error), W'(m_skew));
    check("busy", W'(busy), W'(eb));
  endtask

  task automatic launch(input logic [W-1:0] data);
    row_on[cyc] = 1'b1;
    row_at[cyc] = data;
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Drive this cycle's lanes, take the edge, advance the model, compare.
  task automatic cycle();
    logic [N-1:0] cv;
    logic [W-1:0] cd;
    cv = '0;
    cd = rand_row();
    for (int j = 0; j < N; j++) begin
      if ((cyc >= j) && row_on[cyc-j]) begin
        cv[j] = 1'b1;
        cd[j*DW +: DW] = row_at[cyc-j][j*DW +: DW];
      end
    end
    if (flat_on) begin
      cv = '1;
      cd = flat_data;
    end
    col_valid = cv;
    col_data  = cd;
    @(posedge s_clk);
    model_edge(cv, cd, out_ready, clear);
    #1;
    compare_all();
    cyc++;
    flat_on = 1'b0;
    if (cyc >= SCHED) begin
      $display("FAIL schedule_overrun cycle=%0d limit=%0d", cyc, SCHED);
      $fatal(1, "schedule overrun");
    end
  endtask

  task automatic do_clear();
    flush_sched();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    logic [W-1:0] one_row;
    s_reset   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    col_valid = '0;
    col_data  = '0;
    flat_data = '0;
    flush_sched();
    model_reset();

    // Reset and idle
    #12;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_row_count", W'(row_count), W'(0));
    check("rst_flags", W'({overflow, skew_error, busy}), W'(0));
    repeat (2) cycle();
    s_reset = 1'b1;
    repeat (50) cycle();

    // Single skewed row with known data
    out_ready = 1'b1;
    for (int j = 0; j < N; j++) one_row[j*DW +: DW] = DW'(8'h10 + j);
    launch(one_row);
    repeat (8) cycle();
    check("single_not_early", W'(out_valid), W'(0));
    cycle();
    check("single_valid", W'(out_valid), W'(1));
    check("single_data", out_data, 72'h181716151413121110);
    repeat (5) cycle();
    check("single_count", W'(row_count), W'(1));
    check("single_flags", W'({overflow, skew_error}), W'(0));

    // Burst of 6 rows against a stalled consumer
    do_clear();
    out_ready = 1'b0;
    for (int r = 0; r < 6; r++) begin
      rows[r] = rand_row();
      launch(rows[r]);
      cycle();
    end
    repeat (12) cycle();
    check("burst_count", W'(row_count), W'(4));
    check("burst_overflow", W'(overflow), W'(1));
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check("burst_order", out_data, rows[r]);
      cycle();
    end
    repeat (2) cycle();
    check("burst_drained", W'(out_valid), W'(0));

    // Push into a full FIFO while the head is popped
    do_clear();
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      rows[r] = rand_row();
      launch(rows[r]);
      cycle();
    end
    repeat (7) cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (2) cycle();
    check("fullpop_overflow", W'(overflow), W'(0));
    check("fullpop_count", W'(row_count), W'(5));
    check("fullpop_head", out_data, rows[1]);
    out_ready = 1'b1;
    for (int r = 1; r < 5; r++) begin
      check("fullpop_order", out_data, rows[r]);
      cycle();
    end
    check("fullpop_drained", W'(out_valid), W'(0));

    // Unskewed valids are a fault and never form a row
    do_clear();
    flat_data = rand_row();
    flat_on = 1'b1;
    cycle();
    check("skew_flag", W'(skew_error), W'(1));
    repeat (10) cycle();
    check("skew_no_row", W'(row_count), W'(0));
    do_clear();
    check("skew_cleared", W'({skew_error, overflow}), W'(0));

    // Random traffic, random back-pressure, rare faults and clears
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) launch(rand_row());
      if ($urandom_range(0, 63) == 0) begin
        flat_data = rand_row();
        flat_on = 1'b1;
      end
      clear = ($urandom_range(0, 99) == 0);
      cycle();
      clear = 1'b0;
    end
    out_ready = 1'b1;
    repeat (15) cycle();

    // Reset while rows are buffered and one is in flight
    do_clear();
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      launch(rand_row());
      cycle();
    end
    repeat (8) cycle();
    launch(rand_row());
    repeat (3) cycle();
    check("pre_reset_valid", W'(out_valid), W'(1));
    #1;
    s_reset = 1'b0;
    #1;
    check("async_out_valid", W'(out_valid), W'(0));
    check("async_busy", W'(busy), W'(0));
    check("async_count", W'(row_count), W'(0));
    check("async_out_data", out_data, '0);
    flush_sched();
    model_reset();
    repeat (3) cycle();
    s_reset = 1'b1;
    out_ready = 1'b1;
    repeat (40) cycle();
    check("post_reset_count", W'(row_count), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
